sc_psr_ctrl: RTL and testbench

SC_PSR_CTRL -- requirements
Module: sc_psr_ctrl

---
 rtl/sc_psr_ctrl_pkg.sv | 38 +++
 rtl/sc_psr_cond_eval.sv | 43 ++++
 rtl/sc_psr_ctrl.sv | 119 +++++++++++
 tb/tb_sc_psr_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_psr_ctrl_pkg.sv
// Shared types and constants for the PSR flag-update controller.
// Holds FSM states, {N,Z,V,C} flag bit positions and SPARC icc condition codes.
`timescale 1ns/1ps
package sc_psr_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_COMMIT = 2'd2
  } psr_state_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 0;

  localparam int unsigned COND_W = 4;
  localparam int unsigned CNT_W  = 3;

  // Bit 3 of a condition inverts the base test selected by bits 2:0.
  localparam logic [COND_W-1:0] COND_NEVER  = 4'b0000;
  localparam logic [COND_W-1:0] COND_E      = 4'b0001;
  localparam logic [COND_W-1:0] COND_LE     = 4'b0010;
  localparam logic [COND_W-1:0] COND_L      = 4'b0011;
  localparam logic [COND_W-1:0] COND_LEU    = 4'b0100;
  localparam logic [COND_W-1:0] COND_CS     = 4'b0101;
  localparam logic [COND_W-1:0] COND_NEG    = 4'b0110;
  localparam logic [COND_W-1:0] COND_VS     = 4'b0111;
  localparam logic [COND_W-1:0] COND_ALWAYS = 4'b1000;
  localparam logic [COND_W-1:0] COND_NE     = 4'b1001;
  localparam logic [COND_W-1:0] COND_G      = 4'b1010;
  localparam logic [COND_W-1:0] COND_GE     = 4'b1011;
  localparam logic [COND_W-1:0] COND_GU     = 4'b1100;
  localparam logic [COND_W-1:0] COND_CC     = 4'b1101;
  localparam logic [COND_W-1:0] COND_POS    = 4'b1110;
  localparam logic [COND_W-1:0] COND_VC     = 4'b1111;

endpackage

// File: rtl/sc_psr_cond_eval.sv
// Combinational SPARC icc branch-condition evaluator.
`timescale 1ns/1ps
module sc_psr_cond_eval
  import sc_psr_ctrl_pkg::*;
#(
  parameter int unsigned DATAWIDTH_ALU_SELECTION = 4
) (
  input  logic [COND_W-1:0]                  cond,
  input  logic [DATAWIDTH_ALU_SELECTION-1:0] flags,
  output logic                               taken_c
);

  logic n, z, v, c;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];
  assign c = flags[FLAG_C];

  always_comb begin
    taken_c = 1'b0;
    case (cond)
      COND_NEVER:  taken_c = 1'b0;
      COND_E:      taken_c = z;
      COND_LE:     taken_c = z | (n ^ v);
      COND_L:      taken_c = n ^ v;
      COND_LEU:    taken_c = c | z;
      COND_CS:     taken_c = c;
      COND_NEG:    taken_c = n;
      COND_VS:     taken_c = v;
      COND_ALWAYS: taken_c = 1'b1;
      COND_NE:     taken_c = ~z;
      COND_G:      taken_c = ~(z | (n ^ v));
      COND_GE:     taken_c = ~(n ^ v);
      COND_GU:     taken_c = ~(c | z);
      COND_CC:     taken_c = ~c;
      COND_POS:    taken_c = ~n;
      COND_VC:     taken_c = ~v;
      default:     taken_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/sc_psr_ctrl.sv
// PSR write controller: arbitrates delayed explicit writes against ALU flag
// updates and resolves branches on flags forwarded ahead of the flag register.
`timescale 1ns/1ps
module sc_psr_ctrl
  import sc_psr_ctrl_pkg::*;
#(
  parameter int unsigned DATAWIDTH_ALU_SELECTION = 4,
  parameter int unsigned WRPSR_DELAY             = 3
) (
  input  logic                               SC_PsrCtrl_CLOCK_50,
  input  logic                               SC_PsrCtrl_RESET_InLow,
  input  logic                               SC_PsrCtrl_AluUpdate_In,
  input  logic [DATAWIDTH_ALU_SELECTION-1:0] SC_PsrCtrl_AluFlags_In,
  input  logic                               SC_PsrCtrl_WrReq_In,
  input  logic [DATAWIDTH_ALU_SELECTION-1:0] SC_PsrCtrl_WrData_In,
  input  logic [DATAWIDTH_ALU_SELECTION-1:0] SC_PsrCtrl_Psr_In,
  input  logic                               SC_PsrCtrl_BrEval_In,
  input  logic [COND_W-1:0]                  SC_PsrCtrl_Cond_In,
  output logic                               SC_PsrCtrl_Write_OutLow,
  output logic [DATAWIDTH_ALU_SELECTION-1:0] SC_PsrCtrl_Flags_Out,
  output logic                               SC_PsrCtrl_WrAck_Out,
  output logic                               SC_PsrCtrl_Busy_Out,
  output logic                               SC_PsrCtrl_Conflict_Out,
  output logic                               SC_PsrCtrl_Taken_Out,
  output logic                               SC_PsrCtrl_BrValid_Out
);

  localparam int unsigned FW = DATAWIDTH_ALU_SELECTION;

  psr_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [FW-1:0]   wr_data_q;
  logic            commit_go_c;
  logic [FW-1:0]   commit_data_c;
  logic [FW-1:0]   fwd_flags_c;
  logic            taken_c;

  // commit_go_c marks the edge whose registered outputs form the COMMIT cycle.
  always_comb begin
    commit_go_c   = 1'b0;
    commit_data_c = wr_data_q;
    case (state)
      ST_IDLE: begin
        if (SC_PsrCtrl_WrReq_In && (WRPSR_DELAY == 1)) begin
          commit_go_c   = 1'b1;
          commit_data_c = SC_PsrCtrl_WrData_In;
        end
      end
      ST_DELAY: commit_go_c = (cnt == CNT_W'(1));
      default:  commit_go_c = 1'b0;
    endcase
  end

  // A write still on the output bus has not yet landed in the flag register.
  assign fwd_flags_c = SC_PsrCtrl_Write_OutLow ? SC_PsrCtrl_Psr_In : SC_PsrCtrl_Flags_Out;

  sc_psr_cond_eval #(
    .DATAWIDTH_ALU_SELECTION(DATAWIDTH_ALU_SELECTION)
  ) u_cond_eval (
    .cond    (SC_PsrCtrl_Cond_In),
    .flags   (fwd_flags_c),
    .taken_c (taken_c)
  );

  always_ff @(posedge SC_PsrCtrl_CLOCK_50 or negedge SC_PsrCtrl_RESET_InLow) begin
    if (!SC_PsrCtrl_RESET_InLow) begin
      state                   <= ST_IDLE;
      cnt                     <= '0;
      wr_data_q               <= '0;
      SC_PsrCtrl_Write_OutLow <= 1'b1;
      SC_PsrCtrl_Flags_Out    <= '0;
      SC_PsrCtrl_WrAck_Out    <= 1'b0;
      SC_PsrCtrl_Busy_Out     <= 1'b0;
      SC_PsrCtrl_Conflict_Out <= 1'b0;
      SC_PsrCtrl_Taken_Out    <= 1'b0;
      SC_PsrCtrl_BrValid_Out  <= 1'b0;
    end else begin
      SC_PsrCtrl_WrAck_Out    <= 1'b0;
      SC_PsrCtrl_Conflict_Out <= 1'b0;
      SC_PsrCtrl_Write_OutLow <= 1'b1;
      SC_PsrCtrl_BrValid_Out  <= SC_PsrCtrl_BrEval_In;
      if (SC_PsrCtrl_BrEval_In) begin
        SC_PsrCtrl_Taken_Out <= taken_c;
      end

      case (state)
        ST_IDLE: begin
          if (SC_PsrCtrl_WrReq_In) begin
            wr_data_q           <= SC_PsrCtrl_WrData_In;
            SC_PsrCtrl_Busy_Out <= 1'b1;
            if (WRPSR_DELAY > 1) begin
              state <= ST_DELAY;
              cnt   <= CNT_W'(WRPSR_DELAY - 1);
            end
          end
        end
        ST_DELAY:  cnt <= cnt - CNT_W'(1);
        ST_COMMIT: begin
          state               <= ST_IDLE;
          SC_PsrCtrl_Busy_Out <= 1'b0;
        end
        default:   state <= ST_IDLE;
      endcase

      // The explicit write owns the flag bus on its commit edge; a coincident ALU update is dropped.
      if (commit_go_c) begin
        state                   <= ST_COMMIT;
        SC_PsrCtrl_Write_OutLow <= 1'b0;
        SC_PsrCtrl_Flags_Out    <= commit_data_c;
        SC_PsrCtrl_WrAck_Out    <= 1'b1;
        SC_PsrCtrl_Conflict_Out <= SC_PsrCtrl_AluUpdate_In;
      end else if (SC_PsrCtrl_AluUpdate_In) begin
        SC_PsrCtrl_Write_OutLow <= 1'b0;
        SC_PsrCtrl_Flags_Out    <= SC_PsrCtrl_AluFlags_In;
      end
    end
  end

endmodule

// File: tb/tb_sc_psr_ctrl.sv
// Self-checking bench for sc_psr_ctrl: directed write/ALU/reset sequences and
// a scoreboarded sweep of every branch condition against every flag value.
`timescale 1ns/1ps
module tb_sc_psr_ctrl;

  logic       clk;
  logic       rst_n;
  logic       alu_update;
  logic [3:0] alu_flags;
  logic       wr_req;
  logic [3:0] wr_data;
  logic [3:0] psr_in;
  logic       br_eval;
  logic [3:0] cond;
  logic       write_n;
  logic [3:0] flags_out;
  logic       wr_ack;
  logic       busy;
  logic       conflict;
  logic       taken;
  logic       br_valid;

  logic [3:0] psr_reg;
  logic [3:0] psr_force;
  logic       psr_sel;

  int checks;
  int errors;
  logic exp_q[$];

  typedef struct {
    logic [3:0] cond;
    logic [3:0] flags;
    logic       exp_taken;
  } vec_t;
  vec_t vecs[256];

  sc_psr_ctrl dut (
    .SC_PsrCtrl_CLOCK_50     (clk),
    .SC_PsrCtrl_RESET_InLow  (rst_n),
    .SC_PsrCtrl_AluUpdate_In (alu_update),
    .SC_PsrCtrl_AluFlags_In  (alu_flags),
    .SC_PsrCtrl_WrReq_In     (wr_req),
    .SC_PsrCtrl_WrData_In    (wr_data),
    .SC_PsrCtrl_Psr_In       (psr_in),
    .SC_PsrCtrl_BrEval_In    (br_eval),
    .SC_PsrCtrl_Cond_In      (cond),
    .SC_PsrCtrl_Write_OutLow (write_n),
    .SC_PsrCtrl_Flags_Out    (flags_out),
    .SC_PsrCtrl_WrAck_Out    (wr_ack),
    .SC_PsrCtrl_Busy_Out     (busy),
    .SC_PsrCtrl_Conflict_Out (conflict),
    .SC_PsrCtrl_Taken_Out    (taken),
    .SC_PsrCtrl_BrValid_Out  (br_valid)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // External flag register: captures the bus on the falling edge of a write cycle.
  always @(negedge clk) begin
    if (!rst_n)        psr_reg <= 4'b0000;
    else if (!write_n) psr_reg <= flags_out;
  end

  assign psr_in = psr_sel ? psr_force : psr_reg;

  function automatic logic model_taken(input logic [3:0] c, input logic [3:0] f);
    logic n, z, v, cy, base;
    n = f[3]; z = f[2]; v = f[1]; cy = f[0];
    case (c[2:0])
      3'd0: base = 1'b0;
      3'd1: base = z;
      3'd2: base = z | (n ^ v);
      3'd3: base = n ^ v;
      3'd4: base = cy | z;
      3'd5: base = cy;
      3'd6: base = n;
      default: base = v;
    endcase
    return base ^ c[3];
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and retire any branch result the DUT presents.
  task automatic tick();
    logic e;
    @(negedge clk);
    if (rst_n && br_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL br_unexpected actual=br_valid required=no_result at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk1("br_taken", taken, e);
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk1({tag, "_write_n"}, write_n, 1'b1);
    chk4({tag, "_flags"}, flags_out, 4'b0000);
    chk1({tag, "_ack"}, wr_ack, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_conflict"}, conflict, 1'b0);
    chk1({tag, "_taken"}, taken, 1'b0);
    chk1({tag, "_br_valid"}, br_valid, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    checks = 0; errors = 0;
    rst_n = 1'b0; alu_update = 1'b0; alu_flags = '0; wr_req = 1'b0; wr_data = '0;
    br_eval = 1'b0; cond = '0; psr_force = '0; psr_sel = 1'b0;

    for (int i = 0; i < 256; i++) begin
      vecs[i].cond      = 4'(i >> 4);
      vecs[i].flags     = 4'(i);
      vecs[i].exp_taken = model_taken(vecs[i].cond, vecs[i].flags);
    end

    repeat (2) tick();
    chk_reset_vals("reset");

    // First edge after release takes an ALU update.
    tick();
    rst_n = 1'b1; alu_update = 1'b1; alu_flags = 4'b1010;
    tick();
    alu_update = 1'b0;
    chk1("first_edge_write_n", write_n, 1'b0);
    chk4("first_edge_flags", flags_out, 4'b1010);
    tick();
    chk1("idle_write_n", write_n, 1'b1);
    chk4("idle_flags_hold", flags_out, 4'b1010);
    chk4("idle_psr", psr_reg, 4'b1010);

    // Plain ALU update lands one cycle later and reaches the flag register.
    alu_update = 1'b1; alu_flags = 4'b0100;
    tick();
    alu_update = 1'b0;
    chk1("alu_write_n", write_n, 1'b0);
    chk4("alu_flags", flags_out, 4'b0100);
    tick();
    chk4("alu_psr", psr_reg, 4'b0100);

    // Branch forwarding: register reads 0000 while the bus carries Z=1.
    psr_sel = 1'b1; psr_force = 4'b0000;
    alu_update = 1'b1; alu_flags = 4'b0100;
    tick();
    alu_update = 1'b0; br_eval = 1'b1; cond = 4'b0001; exp_q.push_back(1'b1);
    tick();
    br_eval = 1'b1; cond = 4'b0001; exp_q.push_back(1'b0);
    tick();
    br_eval = 1'b0;
    tick();
    chk1("br_valid_low", br_valid, 1'b0);
    chk1("br_taken_hold", taken, 1'b0);
    psr_sel = 1'b0;
    tick();

    // Explicit write, delay 3; request held through the commit cycle.
    wr_req = 1'b1; wr_data = 4'b1001;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk1($sformatf("wr_busy_c%0d", k), busy, (k <= 3));
      chk1($sformatf("wr_ack_c%0d", k), wr_ack, (k == 3));
      chk1($sformatf("wr_write_n_c%0d", k), write_n, (k != 3));
      if (k == 3) chk4("wr_flags", flags_out, 4'b1001);
      if (k == 4) wr_req = 1'b0;
    end
    chk4("wr_psr", psr_reg, 4'b1001);

    // ALU update aligned with commit is dropped and flagged.
    wr_req = 1'b1; wr_data = 4'b0011;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 2) begin alu_update = 1'b1; alu_flags = 4'b1100; end
      if (k == 3) begin
        alu_update = 1'b0;
        chk1("cf_ack", wr_ack, 1'b1);
        chk1("cf_conflict", conflict, 1'b1);
        chk1("cf_write_n", write_n, 1'b0);
        chk4("cf_flags", flags_out, 4'b0011);
      end
      if (k == 4) begin
        wr_req = 1'b0;
        chk1("cf_conflict_pulse", conflict, 1'b0);
        chk1("cf_after_write_n", write_n, 1'b1);
        chk4("cf_after_flags", flags_out, 4'b0011);
      end
      if (k == 5) chk4("cf_psr", psr_reg, 4'b0011);
    end

    // ALU updates during DELAY and during the COMMIT cycle go through normally.
    wr_req = 1'b1; wr_data = 4'b0101;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) begin alu_update = 1'b1; alu_flags = 4'b0010; end
      if (k == 2) begin
        alu_update = 1'b0;
        chk1("dl_write_n", write_n, 1'b0);
        chk4("dl_flags", flags_out, 4'b0010);
        chk1("dl_busy", busy, 1'b1);
        chk1("dl_conflict", conflict, 1'b0);
      end
      if (k == 3) begin
        chk1("dl_ack", wr_ack, 1'b1);
        chk4("dl_commit_flags", flags_out, 4'b0101);
        chk1("dl_commit_conflict", conflict, 1'b0);
        alu_update = 1'b1; alu_flags = 4'b0110;
      end
      if (k == 4) begin
        alu_update = 1'b0; wr_req = 1'b0;
        chk1("cm_alu_write_n", write_n, 1'b0);
        chk4("cm_alu_flags", flags_out, 4'b0110);
        chk1("cm_alu_conflict", conflict, 1'b0);
      end
    end
    tick();

    // Reset during DELAY abandons the write.
    wr_req = 1'b1; wr_data = 4'b1111;
    tick();
    chk1("rd_busy_before", busy, 1'b1);
    rst_n = 1'b0; wr_req = 1'b0;
    #1;
    chk_reset_vals("rd_async");
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (wr_ack || !write_n || busy) bad++;
    end
    chk1("rd_no_commit", (bad == 0), 1'b1);

    // Sweep all conditions against all flag values, one branch per cycle.
    psr_sel = 1'b1;
    for (int i = 0; i < 256; i++) begin
      tick();
      psr_force = vecs[i].flags; cond = vecs[i].cond; br_eval = 1'b1;
      exp_q.push_back(vecs[i].exp_taken);
    end
    tick();
    br_eval = 1'b0;
    repeat (3) tick();
    chk1("sb_drained", (exp_q.size() == 0), 1'b1);
    chk1("sweep_br_valid_low", br_valid, 1'b0);
    chk1("sweep_taken_hold", taken, vecs[255].exp_taken);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
